// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified-memory port arbiter: bus-width defaults
// common to the core and memory, plus the read-ownership state encodings.
package mem_port_arbiter_pkg;

  localparam int unsigned ARB_ADDR_W = 16;
  localparam int unsigned ARB_DATA_W = 32;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RD_IF = 2'd1;
  localparam logic [1:0] ST_RD_D  = 2'd2;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner select between fetch and load/store: data has priority unless the
// fetch side has been starved long enough.
module mem_arb_pick (
  input  logic if_req,
  input  logic d_req,
  input  logic starved,
  output logic pick_if,
  output logic pick_d
);

  // Data wins any contest except when fetch has hit the starvation limit.
  always_comb begin
    pick_d  = d_req && !(if_req && starved);
    pick_if = if_req && !pick_d;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store.
// One access per cycle; 1-cycle read data is steered back to its issuer.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W     = ARB_ADDR_W,
  parameter int unsigned DATA_W     = ARB_DATA_W,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wstrb,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int unsigned    CNT_W   = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] starve_cnt;
  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic             pick_if;
  logic             pick_d;

  mem_arb_pick u_pick (
    .if_req  (if_req),
    .d_req   (d_req),
    .starved (starve_cnt == CNT_MAX),
    .pick_if (pick_if),
    .pick_d  (pick_d)
  );

  // Grants and memory command from the winner; everything held low in reset.
  always_comb begin
    if_gnt    = 1'b0;
    d_gnt     = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    if (rst) begin
      if_gnt = pick_if;
      d_gnt  = pick_d;
      if (pick_d) begin
        mem_en    = 1'b1;
        mem_we    = d_we;
        mem_addr  = d_addr;
        mem_wdata = d_wdata;
        mem_wstrb = d_wstrb;
      end else if (pick_if) begin
        mem_en   = 1'b1;
        mem_addr = if_addr;
      end
    end
  end

  // Owner of the read data returning next cycle; stores return nothing.
  always_comb begin
    state_nxt = ST_IDLE;
    if (if_gnt)             state_nxt = ST_RD_IF;
    else if (d_gnt && !d_we) state_nxt = ST_RD_D;
  end

  // Response-ownership FSM and registered valids.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ST_IDLE;
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
    end else begin
      state     <= state_nxt;
      if_rvalid <= (state_nxt == ST_RD_IF);
      d_rvalid  <= (state_nxt == ST_RD_D);
    end
  end

  // Consecutive denied fetch cycles, saturating at the starvation limit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (if_req && !if_gnt) begin
      if (starve_cnt != CNT_MAX) starve_cnt <= starve_cnt + 1'b1;
    end else begin
      starve_cnt <= '0;
    end
  end

  // Steer memory read data to whichever requester owns this cycle's return.
  always_comb begin
    if_rdata = '0;
    d_rdata  = '0;
    if (state == ST_RD_IF) if_rdata = mem_rdata;
    else if (state == ST_RD_D) d_rdata = mem_rdata;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 32;
  localparam int unsigned SM = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          if_gnt, if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic [3:0]    d_wstrb = '0;
  logic          d_gnt, d_rvalid;
  logic [DW-1:0] d_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [3:0]    mem_wstrb;
  logic [DW-1:0] mem_rdata;

  int total = 0;
  int bad   = 0;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_wstrb(d_wstrb), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory environment driven by the DUT's command.
  bit [DW-1:0] env_mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_wstrb[b]) env_mem[mem_addr][8*b +: 8] = mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= env_mem[mem_addr];
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: shadow memory, fetch wait length, pending response.
  bit [DW-1:0] shadow [0:(1<<AW)-1];
  int          wait_len = 0;
  bit          pend_v = 0;
  bit          pend_if = 0;
  bit [DW-1:0] pend_data = '0;
  bit          started = 0;

  function automatic bit exp_d_win();
    return rst === 1'b1 && d_req && !(if_req && wait_len >= SM);
  endfunction
  function automatic bit exp_if_win();
    return rst === 1'b1 && if_req && !exp_d_win();
  endfunction

  always @(posedge clk) begin
    bit gd, gi;
    started = 1;
    gd = exp_d_win();
    gi = exp_if_win();
    if (rst !== 1'b1) begin
      pend_v = 0;
      wait_len = 0;
    end else begin
      pend_v = 0;
      if (gd && d_we) begin
        for (int b = 0; b < 4; b++)
          if (d_wstrb[b]) shadow[d_addr][8*b +: 8] = d_wdata[8*b +: 8];
      end else if (gd) begin
        pend_v = 1; pend_if = 0; pend_data = shadow[d_addr];
      end else if (gi) begin
        pend_v = 1; pend_if = 1; pend_data = shadow[if_addr];
      end
      if (if_req && !gi) wait_len = (wait_len + 1 > SM) ? SM : wait_len + 1;
      else wait_len = 0;
    end
  end

  // Per-cycle comparison against the model, mid-cycle.
  always @(negedge clk) begin
    if (started) begin
      bit gd, gi;
      gd = exp_d_win();
      gi = exp_if_win();
      check("d_gnt", 32'(d_gnt), 32'(gd));
      check("if_gnt", 32'(if_gnt), 32'(gi));
      check("mem_en", 32'(mem_en), 32'(gd | gi));
      check("mem_we", 32'(mem_we), 32'(gd & d_we));
      if (gd) begin
        check("mem_addr", 32'(mem_addr), 32'(d_addr));
        check("mem_wstrb", 32'(mem_wstrb), 32'(d_wstrb));
        if (d_we) check("mem_wdata", mem_wdata, d_wdata);
      end else if (gi) begin
        check("mem_addr", 32'(mem_addr), 32'(if_addr));
        check("mem_wstrb", 32'(mem_wstrb), 32'h0);
      end else begin
        check("mem_addr_idle", 32'(mem_addr), 32'h0);
        check("mem_wstrb_idle", 32'(mem_wstrb), 32'h0);
      end
      check("if_rvalid", 32'(if_rvalid), 32'(pend_v & pend_if));
      check("d_rvalid", 32'(d_rvalid), 32'(pend_v & !pend_if));
      check("if_rdata", if_rdata, (pend_v && pend_if) ? pend_data : 32'h0);
      check("d_rdata", d_rdata, (pend_v && !pend_if) ? pend_data : 32'h0);
    end
  end

  task automatic next();
    @(posedge clk); #1;
  endtask

  initial begin
    bit gi, gd;
    for (int i = 0; i < 128; i++) begin
      bit [DW-1:0] v;
      v = $urandom;
      env_mem[i] = v; shadow[i] = v;
    end
    env_mem[0] = 32'h00000093;    shadow[0] = 32'h00000093;
    env_mem[1] = 32'h00100193;    shadow[1] = 32'h00100193;
    env_mem[2] = 32'h00000013;    shadow[2] = 32'h00000013;
    env_mem[16'h40] = 32'hAAAAAAAA; shadow[16'h40] = 32'hAAAAAAAA;

    // Reset with both requests asserted.
    rst = 0; if_req = 1; d_req = 1; d_we = 0; d_addr = 16'h5;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("rst_if_gnt", 32'(if_gnt), 32'h0);
      check("rst_d_gnt", 32'(d_gnt), 32'h0);
      check("rst_mem_en", 32'(mem_en), 32'h0);
      check("rst_if_rvalid", 32'(if_rvalid), 32'h0);
      check("rst_d_rvalid", 32'(d_rvalid), 32'h0);
      next();
    end
    rst = 1;
    @(negedge clk);
    check("first_d_gnt", 32'(d_gnt), 32'h1);
    check("first_if_gnt", 32'(if_gnt), 32'h0);

    // Fetch-only stream.
    next(); d_req = 0; if_addr = 16'h0;
    @(negedge clk);
    check("fetch0_gnt", 32'(if_gnt), 32'h1);
    check("load5_rvalid", 32'(d_rvalid), 32'h1);
    next(); if_addr = 16'h1;
    @(negedge clk);
    check("fetch0_rdata", if_rdata, 32'h00000093);
    next(); if_addr = 16'h2;
    @(negedge clk);
    check("fetch1_rdata", if_rdata, 32'h00100193);
    check("fetch1_d_rvalid", 32'(d_rvalid), 32'h0);
    next(); if_req = 0;
    @(negedge clk);
    check("fetch2_rdata", if_rdata, 32'h00000013);

    // Store then load.
    next(); d_req = 1; d_we = 1; d_addr = 16'h10; d_wdata = 32'hDEADBEEF; d_wstrb = 4'hF;
    @(negedge clk);
    check("store_gnt", 32'(d_gnt), 32'h1);
    check("store_mem_we", 32'(mem_we), 32'h1);
    next(); d_we = 0;
    @(negedge clk);
    check("store_no_rvalid", 32'(d_rvalid), 32'h0);
    next(); d_req = 0;
    @(negedge clk);
    check("load_rvalid", 32'(d_rvalid), 32'h1);
    check("load_rdata", d_rdata, 32'hDEADBEEF);

    // Starvation guard: four data wins, then fetch.
    next(); if_req = 1; if_addr = 16'h20; d_req = 1; d_we = 0; d_addr = 16'h30;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("starve_d_gnt", 32'(d_gnt), 32'h1);
      next();
    end
    @(negedge clk);
    check("starve_if_gnt", 32'(if_gnt), 32'h1);
    check("starve_d_held", 32'(d_gnt), 32'h0);
    next(); if_addr = 16'h21;
    @(negedge clk);
    check("after_starve_d_gnt", 32'(d_gnt), 32'h1);

    // Store and fetch to the same address: store first, fetch sees new data.
    next(); if_addr = 16'h40; d_we = 1; d_addr = 16'h40; d_wdata = 32'h12345678; d_wstrb = 4'h3;
    @(negedge clk);
    check("same_addr_store_gnt", 32'(d_gnt), 32'h1);
    next(); d_req = 0; d_we = 0;
    @(negedge clk);
    check("same_addr_fetch_gnt", 32'(if_gnt), 32'h1);
    next(); if_req = 0;
    @(negedge clk);
    check("same_addr_fetch_rdata", if_rdata, 32'hAAAA5678);

    // Reset while a load is outstanding.
    next(); d_req = 1; d_addr = 16'h30;
    @(negedge clk);
    check("midrst_load_gnt", 32'(d_gnt), 32'h1);
    #1 rst = 0;
    next(); d_req = 0;
    @(negedge clk);
    check("midrst_d_rvalid", 32'(d_rvalid), 32'h0);
    check("midrst_d_rdata", d_rdata, 32'h0);
    next(); rst = 1;

    // Randomized traffic; requests held until granted, occasionally dropped.
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      gi = if_gnt; gd = d_gnt;
      next();
      if (rst == 0) rst = 1;
      else if ($urandom_range(149) == 0) rst = 0;
      if (!if_req || gi || $urandom_range(15) == 0) begin
        if_req  = ($urandom_range(3) != 0);
        if_addr = AW'($urandom_range(63));
      end
      if (!d_req || gd || $urandom_range(15) == 0) begin
        d_req   = ($urandom_range(2) != 0);
        d_we    = $urandom_range(1) == 1;
        d_addr  = AW'($urandom_range(63));
        d_wdata = $urandom;
        d_wstrb = 4'($urandom_range(15));
      end
    end
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Arbitrates the core's single-port unified memory (the 64K-word array loaded from the riscv-tests hex image) between the instruction-fetch stage and the load/store stage. Issues at most one access per cycle. Routes 1-cycle-latency read data back to the requester that issued it. Data accesses have priority, with a starvation guard for fetch. Sits between the core pipeline and the memory instance inside the core.

Parameters:
ADDR_W, 16, word-address width (memory depth 2^ADDR_W words)
DATA_W, 32, data word width
STARVE_MAX, 4, consecutive denied fetch-request cycles before fetch is forced to win

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous reset, active-low (rst==0 resets on rising clk edge)
if_req  in  1  fetch read request; held with if_addr stable until if_gnt
if_addr  in  ADDR_W  fetch word address
if_gnt  out  1  fetch request issued this cycle (combinational)
if_rvalid  out  1  fetch read data valid (registered)
if_rdata  out  DATA_W  fetch read data
d_req  in  1  load/store request; held stable until d_gnt
d_we  in  1  1=store, 0=load
d_addr  in  ADDR_W  data word address
d_wdata  in  DATA_W  store data
d_wstrb  in  DATA_W/8  store byte enables
d_gnt  out  1  data request issued this cycle (combinational)
d_rvalid  out  1  load data valid (registered; never asserted for stores)
d_rdata  out  DATA_W  load data
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory word address
mem_wdata  out  DATA_W  memory write data
mem_wstrb  out  DATA_W/8  memory byte enables
mem_rdata  in  DATA_W  memory read data, valid the cycle after a read issue

Behaviour:
- Reset (rst==0 at edge): state=IDLE, starve_cnt=0, if_rvalid=d_rvalid=0. While rst==0: if_gnt=d_gnt=mem_en=mem_we=0, mem_addr/wdata/wstrb=0.
- Grant logic (combinational, valid when rst==1):
  - Only d_req: data wins.
  - Only if_req: fetch wins.
  - Both asserted: data wins, unless starve_cnt==STARVE_MAX, in which case fetch wins.
  - Winner's gnt=1. mem_en=1; mem_we=winner is data && d_we. mem_addr/wdata/wstrb are taken from the winner. Fetch issue drives mem_wstrb=0.
- FSM (tracks owner of the read returning next cycle):
  - States IDLE, RD_IF, RD_D.
  - Next state each edge: RD_IF if fetch granted; RD_D if a data load is granted; IDLE otherwise (no grant, or a store granted).
  - Transitions are legal from any state, so back-to-back issue happens every cycle with no bubbles.
- Response path:
  - if_rvalid <= (next state==RD_IF); d_rvalid <= (next state==RD_D).
  - In state RD_IF: if_rdata=mem_rdata, d_rdata=0. In state RD_D: d_rdata=mem_rdata, if_rdata=0. In IDLE: both are 0.
  - Read latency: exactly 1 cycle from gnt to rvalid.
  - Stores complete at grant and produce no response.
- Starvation counter:
  - starve_cnt increments (saturating at STARVE_MAX) each cycle with if_req=1 && if_gnt=0.
  - Clears to 0 on if_gnt, or on a cycle with if_req=0.
  - Width is clog2(STARVE_MAX+1).
- Boundary conditions:
  - Address STARVE_MAX guard: at most STARVE_MAX consecutive data wins while fetch is waiting; the next cycle goes to fetch.
  - Store and fetch to the same address in the same cycle: store wins; the fetch issued next cycle sees the new data.
  - Reset while a read is outstanding: the pending rvalid is dropped and never delivered.
  - Requests asserted during reset are not granted. The first grant can occur in the first cycle with rst==1.
  - Requester dropping req before gnt: legal; no access is made.

Decomposition:
- Shared package:
  - FSM state encodings ST_IDLE=2'd0, ST_RD_IF=2'd1, ST_RD_D=2'd2.
  - Defaults for ADDR_W and DATA_W, shared with the core and memory.
- One natural sub-module: mem_arb_pick, a combinational winner select from (if_req, d_req, starve_cnt==STARVE_MAX).
- FSM, counter and muxing stay in mem_port_arbiter.

Test Plan:
- Reset: rst=0 for 2 cycles with if_req=d_req=1 -> no gnt, mem_en=0, both rvalid=0. First rst=1 cycle -> d_gnt=1.
- Fetch-only stream: if_req=1, addresses 0,1,2; memory holds 0x00000093, 0x00100193, 0x00000013 -> if_gnt every cycle, if_rvalid each following cycle with matching data, d_rvalid=0.
- Store then load: d_we=1, addr 0x10, wdata 0xDEADBEEF, wstrb 0xF, then load addr 0x10 -> no rvalid on the store; d_rvalid one cycle after the load grant with 0xDEADBEEF.
- Starvation: if_req=1 and d_req=1 held with continuous loads, STARVE_MAX=4 -> d_gnt 4 cycles, if_gnt on cycle 5, starve_cnt returns to 0, then data wins again.
- Interleaved ownership: alternate fetch grant at 0x20 and load at 0x30 -> rdata lands on the correct requester each cycle, and the other requester's rvalid stays 0.
- Mid-read reset: load granted, rst=0 on the next edge -> d_rvalid stays 0 and state=IDLE.
